fetch_unit: RTL and testbench

- Instruction-fetch stage. Sits directly downstream of the pc register: it reads `pc`, fetches one 19-bit instruction per accepted request over a valid/ready instruction-memory port, and presents it in a registered IF/ID buffer.
- It drives the pc register's `pcwrite` and `next_pc` inputs.
- It handles decode back-pressure (`stall`) and control-flow redirects (`redirect`, `redirect_target`).

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_unit_ifid_buffer.sv | 54 +++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, fetch FSM states
// and the pc register's reset value.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 19;

  localparam logic [PC_W-1:0] PC_RESET = 8'd0;

  typedef enum logic [1:0] {
    WAIT,
    FETCH,
    HOLD
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_unit_ifid_buffer.sv
// IF/ID pipeline buffer: one registered instruction slot with its address.
// Flush beats load, load beats consume (a same-cycle load overwrites the slot).
module ifid_buffer #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               consume_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule : ifid_buffer

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the pc register, issues one fetch per
// accepted request and hands instructions to decode through the IF/ID buffer.
module fetch_unit #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc,
  output logic               pcwrite,
  output logic [PC_W-1:0]    next_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [15:0]        fetch_count
);
  import cpu_pkg::*;

  fetch_state_e state_q;
  logic [15:0]  count_q, count_d;
  logic         redir;
  logic         free;
  logic         accept;
  logic         consume;

  // A redirect wins over everything; its cycle neither requests nor counts a hand-off.
  always_comb begin
    redir    = redirect && (state_q != WAIT);
    free     = !if_valid || !stall;
    imem_req = (state_q == FETCH) && free && !redirect;
    accept   = imem_req && imem_ready;
    consume  = if_valid && !stall && !redir;
    pcwrite  = redir || accept;
    next_pc  = redir ? redirect_target : pc + PC_W'(1);
    count_d  = (consume && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
  end

  assign imem_addr   = pc;
  assign fetch_count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (redir) begin
        state_q <= FETCH;
      end else begin
        case (state_q)
          WAIT:    state_q <= FETCH;
          FETCH:   if (if_valid && stall) state_q <= HOLD;
          HOLD:    if (!stall) state_q <= FETCH;
          default: state_q <= WAIT;
        endcase
      end
    end
  end

  ifid_buffer #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid_buffer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .consume_i (consume),
    .flush_i   (redir),
    .instr_i   (imem_rdata),
    .pc_i      (pc),
    .valid_o   (if_valid),
    .instr_o   (if_instr),
    .pc_o      (if_pc)
  );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: pc register and instruction memory (word at n = 0x100+n)
// modelled here, a cycle-level reference model checks every cycle.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [PC_W-1:0]    pc;
  logic               pcwrite;
  logic [PC_W-1:0]    next_pc;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready = 1'b1;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall = 1'b0;
  logic               redirect = 1'b0;
  logic [PC_W-1:0]    redirect_target = '0;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic [15:0]        fetch_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Environment: the pc register and a combinational instruction memory.
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= PC_RESET;
    else if (pcwrite) pc <= next_pc;
  end
  assign imem_rdata = 19'h100 + 19'(imem_addr);

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pcwrite         (pcwrite),
    .next_pc         (next_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what decode should see, tracked from the rules
  bit m_waiting = 1'b1;
  bit m_blocked = 1'b0;
  bit m_valid   = 1'b0;
  int m_instr   = 0;
  int m_pc      = 0;
  int m_count   = 0;
  bit e_redir, e_free, e_req, e_acc, e_cons;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req", imem_req, 0);
      chk("rst_pcwrite", pcwrite, 0);
      chk("rst_valid", if_valid, 0);
      chk("rst_count", fetch_count, 0);
      chk("rst_ifpc", if_pc, 0);
      chk("rst_instr", if_instr, 0);
      m_waiting = 1'b1;
      m_blocked = 1'b0;
      m_valid   = 1'b0;
      m_instr   = 0;
      m_pc      = 0;
      m_count   = 0;
    end else begin
      e_redir = redirect && !m_waiting;
      e_free  = !m_valid || !stall;
      e_req   = !m_waiting && !m_blocked && e_free && !redirect;
      e_acc   = e_req && imem_ready;
      chk("m_req", imem_req, e_req);
      chk("m_pcwrite", pcwrite, e_redir || e_acc);
      chk("m_addr", imem_addr, pc);
      if (e_redir) chk("m_next_pc_redir", next_pc, redirect_target);
      else if (e_acc) chk("m_next_pc_inc", next_pc, (int'(pc) + 1) % 256);
      chk("m_valid", if_valid, m_valid);
      if (m_valid) begin
        chk("m_instr", if_instr, m_instr);
        chk("m_ifpc", if_pc, m_pc);
      end
      chk("m_count", fetch_count, m_count);
      // Advance to the state after the coming edge.
      if (m_waiting) begin
        m_waiting = 1'b0;
      end else if (e_redir) begin
        m_valid   = 1'b0;
        m_blocked = 1'b0;
      end else begin
        e_cons    = m_valid && !stall;
        m_blocked = m_valid && stall;
        if (e_cons && m_count < 65535) m_count++;
        if (e_acc) begin
          m_valid = 1'b1;
          m_instr = 'h100 + int'(pc);
          m_pc    = int'(pc);
        end else if (e_cons) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int guard;

  initial begin
    // Reset release and streaming
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); chk("wait_no_req", imem_req, 0);
    @(negedge clk); chk("first_req", imem_req, 1);
    chk("first_pcwrite", pcwrite, 1); chk("first_addr", imem_addr, 0);
    @(negedge clk); chk("seq0_instr", if_instr, 'h100); chk("seq0_pc", if_pc, 0);
    @(negedge clk); chk("seq1_instr", if_instr, 'h101); chk("seq1_pc", if_pc, 1);
    @(negedge clk); chk("seq2_instr", if_instr, 'h102); chk("seq2_pc", if_pc, 2);
    chk("seq2_pcwrite", pcwrite, 1);

    // Stall while 0x105 is buffered
    guard = 0;
    while (!(if_valid && if_instr == 19'h105) && guard < 20) begin
      tick();
      guard++;
    end
    chk("stall_reach_105", guard < 20, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req", imem_req, 0); chk("stall_pcwrite", pcwrite, 0);
      chk("stall_instr", if_instr, 'h105); chk("stall_count", fetch_count, 5);
      tick();
    end
    stall = 1'b0;
    @(negedge clk); chk("unstall_req", imem_req, 0); chk("unstall_count", fetch_count, 5);
    @(negedge clk); chk("after_consume_valid", if_valid, 0);
    chk("after_consume_count", fetch_count, 6); chk("refetch_addr", imem_addr, 6);
    @(negedge clk); chk("instr_106", if_instr, 'h106); chk("count_106", fetch_count, 6);

    // Redirect
    tick(); redirect = 1'b1; redirect_target = 8'h40;
    @(negedge clk); chk("redir_pcwrite", pcwrite, 1);
    chk("redir_next_pc", next_pc, 'h40); chk("redir_req", imem_req, 0);
    tick(); redirect = 1'b0;
    @(negedge clk); chk("redir_flush", if_valid, 0); chk("redir_count", fetch_count, 7);
    @(negedge clk); chk("redir_ifpc", if_pc, 'h40); chk("redir_instr", if_instr, 'h140);

    // Memory wait at pc=7
    tick(); redirect = 1'b1; redirect_target = 8'h07;
    tick(); redirect = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mw_req", imem_req, 1); chk("mw_addr", imem_addr, 7); chk("mw_pcwrite", pcwrite, 0);
      tick();
    end
    imem_ready = 1'b1;
    @(negedge clk); chk("mw_accept", pcwrite, 1);
    @(negedge clk); chk("mw_ifpc", if_pc, 7); chk("mw_instr", if_instr, 'h107);

    // pc wrap
    tick(); redirect = 1'b1; redirect_target = 8'hFF;
    tick(); redirect = 1'b0;
    @(negedge clk); chk("wrap_next_pc", next_pc, 0); chk("wrap_addr", imem_addr, 'hFF);
    @(negedge clk); chk("wrap_ifpc_ff", if_pc, 'hFF);
    @(negedge clk); chk("wrap_ifpc_0", if_pc, 0);

    // Randomized traffic, checked by the model
    repeat (2000) begin
      tick();
      stall           = ($urandom_range(0, 9) < 3);
      imem_ready      = ($urandom_range(0, 9) < 7);
      redirect        = ($urandom_range(0, 19) == 0);
      redirect_target = 8'($urandom_range(0, 255));
    end

    // Counter saturation
    tick(); stall = 1'b0; imem_ready = 1'b1; redirect = 1'b0;
    repeat (65600) @(posedge clk);
    @(negedge clk); chk("count_sat", fetch_count, 'hFFFF);
    @(negedge clk); chk("count_sat_hold", fetch_count, 'hFFFF);

    // Asynchronous reset in the middle of a stall
    tick(); stall = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", if_valid, 0); chk("areset_ifpc", if_pc, 0);
    chk("areset_count", fetch_count, 0); chk("areset_req", imem_req, 0);
    chk("areset_pcwrite", pcwrite, 0);
    stall = 1'b0;
    tick(); reset = 1'b0;
    @(negedge clk); chk("post_rst_req", imem_req, 0); chk("post_rst_pcwrite", pcwrite, 0);
    @(negedge clk); chk("post_rst_first_req", imem_req, 1); chk("post_rst_addr", imem_addr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_unit
